// File: rtl/reg4.sv
// Parallel-load holding register with clock enable and asynchronous active-low reset.
// parallel_out comes straight from the flops; there is no path from parallel_in to the output.
module reg4 #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out
);

  // Reset wins over cen, including on an edge where both are active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= RST_VAL;
    end else if (cen) begin
      parallel_out <= parallel_in;
    end
  end

endmodule

// File: tb/tb_reg4.sv
// Bench for reg4: expected values are queued as stimulus is driven and compared against the output.
// Inputs change 1 time unit after a rising edge; the output is sampled there or between edges.
module tb_reg4;

  logic       clk;
  logic       rst;
  logic       cen;
  logic [3:0] parallel_in;
  logic [3:0] parallel_out;

  logic [3:0] exp_q[$];
  logic [3:0] model;
  logic [3:0] exp_val;
  int         vectors;
  int         miscompares;

  reg4 #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .cen          (cen),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    cen         = 1'b1;
    parallel_in = 4'b1111;
    model       = 4'b0000;
    #1;
    // Before the first clk edge: output must already be cleared.
    exp_q.push_back(model);
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL reset_pre_edge: got %b expected %b", parallel_out, exp_val);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model);
      edge_wait();
      vectors++;
      exp_val = exp_q.pop_front();
      if (parallel_out !== exp_val) begin
        miscompares++;
        $display("FAIL reset_edge%0d: got %b expected %b", i, parallel_out, exp_val);
      end
    end
    rst = 1'b1;
    cen = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] data[2] = '{4'b1010, 4'b0101};
    cen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      parallel_in = data[i];
      model       = data[i];
      exp_q.push_back(model);
      edge_wait();
      vectors++;
      exp_val = exp_q.pop_front();
      if (parallel_out !== exp_val) begin
        miscompares++;
        $display("FAIL load%0d: got %b expected %b", i, parallel_out, exp_val);
      end
    end
  endtask

  task automatic test_hold();
    cen         = 1'b0;
    parallel_in = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model);
      edge_wait();
      vectors++;
      exp_val = exp_q.pop_front();
      if (parallel_out !== exp_val) begin
        miscompares++;
        $display("FAIL hold%0d: got %b expected %b", i, parallel_out, exp_val);
      end
    end
  endtask

  task automatic test_reenable();
    cen         = 1'b1;
    parallel_in = 4'b0111;
    model       = 4'b0111;
    exp_q.push_back(model);
    edge_wait();
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL reenable: got %b expected %b", parallel_out, exp_val);
    end
  endtask

  task automatic test_mid_reset();
    cen = 1'b1;
    #2;
    rst   = 1'b0;
    model = 4'b0000;
    exp_q.push_back(model);
    #1;
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b expected %b", parallel_out, exp_val);
    end
    rst = 1'b1;
    exp_q.push_back(model);
    #1;
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL mid_reset_release: got %b expected %b", parallel_out, exp_val);
    end
    parallel_in = 4'b1100;
    model       = 4'b1100;
    exp_q.push_back(model);
    edge_wait();
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL mid_reset_reload: got %b expected %b", parallel_out, exp_val);
    end
  endtask

  task automatic test_glitch();
    cen         = 1'b1;
    parallel_in = 4'b0011;
    exp_q.push_back(model);
    #2;
    parallel_in = 4'b1001;
    #1;
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL glitch_between_edges: got %b expected %b", parallel_out, exp_val);
    end
    model = 4'b1001;
    exp_q.push_back(model);
    edge_wait();
    vectors++;
    exp_val = exp_q.pop_front();
    if (parallel_out !== exp_val) begin
      miscompares++;
      $display("FAIL glitch_at_edge: got %b expected %b", parallel_out, exp_val);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      cen         = 1'($urandom_range(0, 1));
      parallel_in = 4'($urandom_range(0, 15));
      if (cen) model = parallel_in;
      exp_q.push_back(model);
      edge_wait();
      vectors++;
      exp_val = exp_q.pop_front();
      if (parallel_out !== exp_val) begin
        miscompares++;
        $display("FAIL back_to_back%0d: got %b expected %b (cen=%b)", i, parallel_out, exp_val, cen);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load();
    test_hold();
    test_reenable();
    test_mid_reset();
    test_glitch();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
